// File: rtl/tpg_timing_ctrl.sv
// Timing-set controller for the test pattern generator: shadow register file,
// validated atomic commit to the active set, frame-aligned start/stop and frame counting.
module tpg_timing_ctrl #(
    parameter int H_BITS = 12,
    parameter int V_BITS = 12,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_vld,
    output logic              wr_rdy,
    input  logic [3:0]        wr_addr,
    input  logic [15:0]       wr_data,
    input  logic              vs_q,
    output logic              tpg_rst,
    output logic [H_BITS-1:0] tHS_START,
    output logic [H_BITS-1:0] tHS_END,
    output logic [H_BITS-1:0] tHACT_START,
    output logic [H_BITS-1:0] tHACT_END,
    output logic [H_BITS-1:0] tH_END,
    output logic [V_BITS-1:0] tVS_START,
    output logic [V_BITS-1:0] tVS_END,
    output logic [V_BITS-1:0] tVACT_START,
    output logic [V_BITS-1:0] tVACT_END,
    output logic [H_BITS-1:0] tV_END,
    output logic              busy,
    output logic              cfg_err,
    output logic [FCNT_W-1:0] frame_cnt
);
    localparam int MW = (H_BITS > V_BITS) ? H_BITS : V_BITS;
    localparam logic [MW-1:0] H_MASK = MW'({H_BITS{1'b1}});
    localparam logic [MW-1:0] V_MASK = MW'({V_BITS{1'b1}});

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN, ST_STOP_PEND} state_t;

    state_t            state_reg, state_fb, state_next;
    logic              tpg_rst_reg, busy_reg, err_reg, err_next;
    logic              apply_pend_reg, pend_next, vs_d_reg;
    logic [FCNT_W-1:0] frame_cnt_reg;
    logic [MW-1:0]     shadow_reg [10];
    logic [MW-1:0]     active_reg [10];
    logic [MW-1:0]     field_mask [10];
    logic [MW-1:0]     wr_ext;
    logic              fb, wr_fire, ctrl_wr, apply_cmd, cfg_ok;
    logic              commit, count_frame;
    logic              unused_data;

    // Fields 5..8 are vertical; everything else, including tV_END, uses the H width.
    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_mask
            assign field_mask[gi] = (gi >= 5 && gi <= 8) ? V_MASK : H_MASK;
        end
    endgenerate

    assign wr_ext      = MW'(wr_data);
    assign unused_data = ^wr_data[15:3];

    always_comb begin
        fb        = vs_q & ~vs_d_reg;
        wr_fire   = wr_vld & ~apply_pend_reg;
        ctrl_wr   = wr_fire && (wr_addr == 4'd10);
        apply_cmd = ctrl_wr & wr_data[1];
        cfg_ok    = (shadow_reg[0] < shadow_reg[1]) && (shadow_reg[1] <= shadow_reg[4]) &&
                    (shadow_reg[2] < shadow_reg[3]) && (shadow_reg[3] <= shadow_reg[4]) &&
                    (shadow_reg[5] < shadow_reg[6]) && (shadow_reg[6] <= shadow_reg[9]) &&
                    (shadow_reg[7] < shadow_reg[8]) && (shadow_reg[8] <= shadow_reg[9]);
        count_frame = fb && (state_reg == ST_RUN || state_reg == ST_STOP_PEND);

        // Boundary effects are resolved first; a same-cycle command then acts on the result.
        state_fb = state_reg;
        if (state_reg == ST_START)
            state_fb = ST_RUN;
        else if (fb && state_reg == ST_STOP_PEND)
            state_fb = ST_IDLE;

        state_next = state_fb;
        if (ctrl_wr) begin
            if (state_fb == ST_IDLE && wr_data[0])
                state_next = ST_START;
            else if (state_fb == ST_RUN && !wr_data[0])
                state_next = ST_STOP_PEND;
            else if (state_fb == ST_STOP_PEND && wr_data[0])
                state_next = ST_RUN;
        end

        commit    = fb & apply_pend_reg;
        pend_next = apply_pend_reg & ~fb;
        if (apply_cmd && cfg_ok) begin
            if (state_fb == ST_IDLE)
                commit = 1'b1;
            else
                pend_next = 1'b1;
        end

        err_next = err_reg;
        if (apply_cmd && !cfg_ok)
            err_next = 1'b1;
        else if (ctrl_wr && wr_data[2])
            err_next = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            tpg_rst_reg    <= 1'b1;
            busy_reg       <= 1'b0;
            err_reg        <= 1'b0;
            apply_pend_reg <= 1'b0;
            vs_d_reg       <= 1'b0;
            frame_cnt_reg  <= '0;
            for (int i = 0; i < 10; i++) begin
                shadow_reg[i] <= '0;
                active_reg[i] <= '0;
            end
        end else begin
            vs_d_reg       <= vs_q;
            state_reg      <= state_next;
            tpg_rst_reg    <= (state_next == ST_IDLE) || (state_next == ST_START);
            busy_reg       <= (state_next != ST_IDLE);
            err_reg        <= err_next;
            apply_pend_reg <= pend_next;
            if (count_frame)
                frame_cnt_reg <= frame_cnt_reg + FCNT_W'(1);
            for (int i = 0; i < 10; i++) begin
                if (wr_fire && wr_addr == 4'(i))
                    shadow_reg[i] <= wr_ext & field_mask[i];
                if (commit)
                    active_reg[i] <= shadow_reg[i];
            end
        end
    end

    assign wr_rdy      = ~apply_pend_reg;
    assign tpg_rst     = tpg_rst_reg;
    assign busy        = busy_reg;
    assign cfg_err     = err_reg;
    assign frame_cnt   = frame_cnt_reg;
    assign tHS_START   = active_reg[0][H_BITS-1:0];
    assign tHS_END     = active_reg[1][H_BITS-1:0];
    assign tHACT_START = active_reg[2][H_BITS-1:0];
    assign tHACT_END   = active_reg[3][H_BITS-1:0];
    assign tH_END      = active_reg[4][H_BITS-1:0];
    assign tVS_START   = active_reg[5][V_BITS-1:0];
    assign tVS_END     = active_reg[6][V_BITS-1:0];
    assign tVACT_START = active_reg[7][V_BITS-1:0];
    assign tVACT_END   = active_reg[8][V_BITS-1:0];
    assign tV_END      = active_reg[9][H_BITS-1:0];
endmodule

// File: tb/tb_tpg_timing_ctrl.sv
// Directed and random checks of tpg_timing_ctrl against a per-cycle behavioural model.
module tb_tpg_timing_ctrl;
    localparam int M_IDLE = 0, M_START = 1, M_RUN = 2, M_STOP = 3;
    localparam int FMASK = 'hFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_vld = 1'b0;
    logic        wr_rdy;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        vs_q = 1'b0;
    logic        tpg_rst, busy, cfg_err;
    logic [11:0] tHS_START, tHS_END, tHACT_START, tHACT_END, tH_END;
    logic [11:0] tVS_START, tVS_END, tVACT_START, tVACT_END, tV_END;
    logic [15:0] frame_cnt;

    int  n_total = 0;
    int  n_bad = 0;
    bit  vs_auto = 0;

    // reference model state
    int  m_shadow [10];
    int  m_active [10];
    int  m_mode, m_fcnt;
    bit  m_pend, m_err, m_vs_prev;

    int  base [10] = '{16, 112, 160, 800, 800, 10, 12, 45, 525, 525};

    tpg_timing_ctrl dut (
        .clk(clk), .rst(rst), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
        .wr_addr(wr_addr), .wr_data(wr_data), .vs_q(vs_q), .tpg_rst(tpg_rst),
        .tHS_START(tHS_START), .tHS_END(tHS_END), .tHACT_START(tHACT_START),
        .tHACT_END(tHACT_END), .tH_END(tH_END), .tVS_START(tVS_START),
        .tVS_END(tVS_END), .tVACT_START(tVACT_START), .tVACT_END(tVACT_END),
        .tV_END(tV_END), .busy(busy), .cfg_err(cfg_err), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dut_field(input int i);
        case (i)
            0: return int'(tHS_START);
            1: return int'(tHS_END);
            2: return int'(tHACT_START);
            3: return int'(tHACT_END);
            4: return int'(tH_END);
            5: return int'(tVS_START);
            6: return int'(tVS_END);
            7: return int'(tVACT_START);
            8: return int'(tVACT_END);
            default: return int'(tV_END);
        endcase
    endfunction

    // Each (start, end, total) triple must satisfy start < end <= total.
    function automatic bit set_ok();
        int t [4][3] = '{'{0, 1, 4}, '{2, 3, 4}, '{5, 6, 9}, '{7, 8, 9}};
        for (int k = 0; k < 4; k++)
            if (!(m_shadow[t[k][0]] < m_shadow[t[k][1]] && m_shadow[t[k][1]] <= m_shadow[t[k][2]]))
                return 0;
        return 1;
    endfunction

    task automatic model_step();
        bit fb, fire, running, bad;
        if (rst) begin
            foreach (m_shadow[i]) begin m_shadow[i] = 0; m_active[i] = 0; end
            m_mode = M_IDLE; m_fcnt = 0; m_pend = 0; m_err = 0; m_vs_prev = 0;
            return;
        end
        fb        = vs_q && !m_vs_prev;
        m_vs_prev = vs_q;
        fire      = wr_vld && !m_pend;
        running   = (m_mode == M_RUN || m_mode == M_STOP);
        if (fb && running) m_fcnt = (m_fcnt + 1) % 65536;
        if (fb && m_pend) begin m_active = m_shadow; m_pend = 0; end
        if (m_mode == M_START) m_mode = M_RUN;
        else if (fb && m_mode == M_STOP) m_mode = M_IDLE;
        if (fire && wr_addr < 10) begin
            m_shadow[wr_addr] = int'(wr_data) & FMASK;
        end else if (fire && wr_addr == 10) begin
            bad = wr_data[1] && !set_ok();
            if (wr_data[1] && !bad) begin
                if (m_mode == M_IDLE) m_active = m_shadow;
                else m_pend = 1;
            end
            if (bad) m_err = 1;
            else if (wr_data[2]) m_err = 0;
            if (m_mode == M_IDLE && wr_data[0]) m_mode = M_START;
            else if (m_mode == M_RUN && !wr_data[0]) m_mode = M_STOP;
            else if (m_mode == M_STOP && wr_data[0]) m_mode = M_RUN;
        end
    endtask

    task automatic check_all();
        check_val("tpg_rst", tpg_rst, (m_mode == M_IDLE || m_mode == M_START));
        check_val("busy", busy, (m_mode != M_IDLE));
        check_val("wr_rdy", wr_rdy, !m_pend);
        check_val("cfg_err", cfg_err, m_err);
        check_val("frame_cnt", frame_cnt, m_fcnt);
        for (int i = 0; i < 10; i++)
            check_val($sformatf("active%0d", i), dut_field(i), m_active[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        if (vs_auto) vs_q = ($urandom_range(0, 7) == 0);
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        bit acc = 0;
        wr_vld = 1'b1; wr_addr = a; wr_data = d;
        for (int n = 0; n < 300 && !acc; n++) begin
            acc = wr_rdy;
            tick();
        end
        wr_vld = 1'b0;
        check_val("wr_accept", acc, 1);
        $display("wr addr=%0d data=0x%04h", a, d);
    endtask

    task automatic vs_pulse();
        vs_q = 1'b1; tick();
        vs_q = 1'b0; tick(); tick();
    endtask

    initial begin
        // reset state
        tick(); tick();
        check_val("rst_tpg_rst", tpg_rst, 1);
        check_val("rst_fcnt", frame_cnt, 0);
        check_val("rst_rdy", wr_rdy, 1);
        rst = 1'b0; tick();

        // idle configuration, committed one cycle after the control write
        for (int i = 0; i < 10; i++) wr(4'(i), 16'(base[i]));
        wr(4'd10, 16'h2);
        check_val("idle_tH_END", tH_END, 800);
        check_val("idle_tHS_START", tHS_START, 16);
        check_val("idle_tV_END", tV_END, 525);
        check_val("idle_err", cfg_err, 0);
        check_val("idle_tpg_rst", tpg_rst, 1);

        // invalid set is rejected, clr_err clears
        wr(4'd3, 16'd900);
        wr(4'd10, 16'h2);
        check_val("bad_err", cfg_err, 1);
        check_val("bad_tHACT_END", tHACT_END, 800);
        wr(4'd10, 16'h4);
        check_val("clr_err", cfg_err, 0);
        wr(4'd3, 16'd800);

        // start: one cycle of tpg reset, then release
        wr(4'd10, 16'h1);
        check_val("start_tpg_rst", tpg_rst, 1);
        tick();
        check_val("run_tpg_rst", tpg_rst, 0);
        check_val("run_busy", busy, 1);
        repeat (3) vs_pulse();
        check_val("run_fcnt3", frame_cnt, 3);

        // apply while running waits for a frame boundary
        wr(4'd4, 16'd1000);
        wr(4'd10, 16'h3);
        check_val("pend_rdy", wr_rdy, 0);
        check_val("pend_tH_END", tH_END, 800);
        tick(); tick();
        check_val("pend_tH_END2", tH_END, 800);
        vs_q = 1'b1; tick();
        check_val("commit_tH_END", tH_END, 1000);
        check_val("commit_rdy", wr_rdy, 1);
        vs_q = 1'b0; tick();

        // stop command coinciding with a boundary
        vs_q = 1'b1;
        wr(4'd10, 16'h0);
        check_val("stop_fcnt", frame_cnt, 5);
        check_val("stop_busy", busy, 1);
        vs_q = 1'b0; tick(); tick();
        check_val("stop_pend_tpg_rst", tpg_rst, 0);
        vs_q = 1'b1; tick();
        check_val("stopped_tpg_rst", tpg_rst, 1);
        check_val("stopped_busy", busy, 0);
        check_val("stopped_fcnt", frame_cnt, 6);
        vs_q = 1'b0; tick();

        // reset while an apply is pending
        wr(4'd10, 16'h1); tick();
        wr(4'd10, 16'h3);
        check_val("rp_rdy", wr_rdy, 0);
        rst = 1'b1; tick();
        check_val("rp_tH_END", tH_END, 0);
        check_val("rp_rdy2", wr_rdy, 1);
        check_val("rp_tpg_rst", tpg_rst, 1);
        check_val("rp_fcnt", frame_cnt, 0);
        rst = 1'b0; tick();

        // random traffic with free-running vsync
        vs_auto = 1;
        for (int k = 0; k < 300; k++) begin
            int r = $urandom_range(0, 99);
            if (r < 2) begin
                rst = 1'b1; tick(); rst = 1'b0;
            end else if (r < 14) begin
                for (int i = 0; i < 10; i++) begin
                    int v = base[i];
                    if ($urandom_range(0, 5) == 0) v = v + $urandom_range(0, 40) - 20;
                    wr(4'(i), 16'(v));
                end
            end else if (r < 55) begin
                int a = $urandom_range(0, 15);
                wr(4'(a), (a < 10 && $urandom_range(0, 1) == 1) ?
                          16'(base[a] + $urandom_range(0, 30)) : 16'($urandom));
            end else begin
                wr(4'd10, 16'($urandom_range(0, 7)));
            end
            repeat ($urandom_range(0, 3)) tick();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
